// File: rtl/valid_ctrl_pkg.sv
// Shared definitions for the L1 D-cache valid-bit array controller:
// geometry, request opcodes, FSM states, the latched request payload
// and a way-mask helper.
package valid_ctrl_pkg;

  localparam int unsigned NUM_SET = 128;
  localparam int unsigned NUM_WAY = 8;
  localparam int unsigned SET_W   = $clog2(NUM_SET);
  localparam int unsigned WAY_W   = $clog2(NUM_WAY);
  localparam int unsigned ADDR_W  = 32;

  typedef enum logic [1:0] {
    OP_LOOKUP  = 2'b00,
    OP_SET_WAY = 2'b01,
    OP_CLR_WAY = 2'b10,
    OP_CLR_SET = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_RDATA = 3'd3,
    ST_FLUSH = 3'd4
  } state_e;

  // Request captured at accept time, consumed in the read-data cycle.
  typedef struct packed {
    op_e              op;
    logic [SET_W-1:0] set;
    logic [WAY_W-1:0] way;
  } req_t;

  // One-hot mask selecting a single way of a valid vector.
  function automatic logic [NUM_WAY-1:0] way_mask(input logic [WAY_W-1:0] way);
    return NUM_WAY'(1) << way;
  endfunction

endpackage

// File: rtl/valid_ctrl.sv
// Controller for the valid-bit array: zero-init sweep after reset,
// whole-array flush sweep, and lookup / read-modify-write way updates.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   flush_req           one-cycle pulse, invalidate all sets
//   flush_busy          high while the init or flush sweep runs
//   req_valid/ready     request handshake (accept when both high)
//   req_op/set/way      operation, target set, target way
//   rsp_valid/rsp_vec   one-cycle response strobe and valid vector
//   mem_en/rd_wr        array enable, 0 = read / 1 = write
//   mem_addr/mem_wdata  array address (zero-extended set) and write data
//   mem_rdata           array read data, valid the cycle after a read
//
// The array interface and handshake are combinational from state and
// inputs: the read is issued in the accept cycle and the write-back in
// the following cycle so the response lands one cycle after accept.
module valid_ctrl
  import valid_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_req,
  output logic               flush_busy,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [SET_W-1:0]   req_set,
  input  logic [WAY_W-1:0]   req_way,
  output logic               rsp_valid,
  output logic [NUM_WAY-1:0] rsp_vec,
  output logic               mem_en,
  output logic               rd_wr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [NUM_WAY-1:0] mem_wdata,
  input  logic [NUM_WAY-1:0] mem_rdata
);

  state_e             state_q, state_d;
  logic [SET_W-1:0]   cnt_q, cnt_d;
  logic               flush_pend_q, flush_pend_d;
  req_t               req_q, req_d;
  logic [NUM_WAY-1:0] rsp_vec_q, rsp_vec_d;
  logic [NUM_WAY-1:0] new_vec;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_BOOT;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      req_q        <= '0;
      rsp_vec_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      req_q        <= req_d;
      rsp_vec_q    <= rsp_vec_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    req_d        = req_q;
    rsp_vec_d    = rsp_vec_q;
    new_vec      = '0;
    flush_busy   = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_vec      = rsp_vec_q;
    mem_en       = 1'b0;
    rd_wr        = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state_q)
      ST_BOOT: begin
        flush_busy = 1'b1;
        state_d    = ST_INIT;
      end

      // Init and flush share one zero-write sweep; flush_req is ignored
      // here because every set is being cleared anyway.
      ST_INIT, ST_FLUSH: begin
        flush_busy = 1'b1;
        mem_en     = 1'b1;
        rd_wr      = 1'b1;
        mem_addr   = ADDR_W'(cnt_q);
        if (cnt_q == SET_W'(NUM_SET - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + SET_W'(1);
        end
      end

      // Flush (new or pending) wins over a simultaneous request.
      ST_IDLE: begin
        req_ready = ~flush_req & ~flush_pend_q;
        if (flush_req || flush_pend_q) begin
          flush_pend_d = 1'b0;
          state_d      = ST_FLUSH;
        end else if (req_valid) begin
          mem_en   = 1'b1;
          mem_addr = ADDR_W'(req_set);
          req_d    = '{op: op_e'(req_op), set: req_set, way: req_way};
          state_d  = ST_RDATA;
        end
      end

      // Old vector is on mem_rdata; respond and write back the new one.
      ST_RDATA: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
        if (flush_req) begin
          flush_pend_d = 1'b1;
        end
        case (req_q.op)
          OP_LOOKUP:  new_vec = mem_rdata;
          OP_SET_WAY: new_vec = mem_rdata | way_mask(req_q.way);
          OP_CLR_WAY: new_vec = mem_rdata & ~way_mask(req_q.way);
          default:    new_vec = '0;
        endcase
        rsp_vec   = new_vec;
        rsp_vec_d = new_vec;
        if (req_q.op != OP_LOOKUP) begin
          mem_en    = 1'b1;
          rd_wr     = 1'b1;
          mem_addr  = ADDR_W'(req_q.set);
          mem_wdata = new_vec;
        end
      end

      default: state_d = ST_BOOT;
    endcase
  end

endmodule

// File: tb/tb_valid_ctrl.sv
// Bench for valid_ctrl: emulates the single-port valid array, keeps a
// per-set reference table of valid vectors updated by the request rules,
// and drives directed plus randomized request / flush / reset traffic.
module tb_valid_ctrl;
  import valid_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush_req = 1'b0;
  logic               flush_busy;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [1:0]         req_op = 2'b00;
  logic [SET_W-1:0]   req_set = '0;
  logic [WAY_W-1:0]   req_way = '0;
  logic               rsp_valid;
  logic [NUM_WAY-1:0] rsp_vec;
  logic               mem_en;
  logic               rd_wr;
  logic [ADDR_W-1:0]  mem_addr;
  logic [NUM_WAY-1:0] mem_wdata;
  logic [NUM_WAY-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] ref_vec [NUM_SET];
  logic [7:0] last_rsp = 8'h00;
  logic       junk_fill = 1'b1;
  logic [7:0] arr [NUM_SET];

  always #5 clk = ~clk;

  valid_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_set    (req_set),
    .req_way    (req_way),
    .rsp_valid  (rsp_valid),
    .rsp_vec    (rsp_vec),
    .mem_en     (mem_en),
    .rd_wr      (rd_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous single-port array, seeded with garbage before init.
  always @(posedge clk) begin
    if (junk_fill) begin
      for (int i = 0; i < NUM_SET; i++) arr[i] <= 8'($urandom);
    end else if (mem_en) begin
      if (rd_wr) arr[mem_addr[SET_W-1:0]] <= mem_wdata;
      else       mem_rdata <= arr[mem_addr[SET_W-1:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < NUM_SET; i++) ref_vec[i] = 8'h00;
  endtask

  task automatic chk_reset(input string tag);
    check(tag, 64'({mem_en, rd_wr, mem_addr, mem_wdata, req_ready, rsp_valid, rsp_vec, flush_busy}),
          64'({1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1}));
  endtask

  // Optional BOOT cycle followed by NUM_SET zero writes in address order.
  task automatic check_sweep(input bit with_boot, input bit noise);
    if (with_boot) begin
      @(negedge clk);
      flush_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check("boot", 64'({flush_busy, req_ready, mem_en}), 64'(3'b100));
    end
    for (int i = 0; i < NUM_SET; i++) begin
      @(negedge clk);
      flush_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      check("sweep", 64'({flush_busy, req_ready, mem_en, rd_wr, mem_addr, mem_wdata}),
            64'({1'b1, 1'b0, 1'b1, 1'b1, 32'(i), 8'h00}));
    end
    clear_ref();
  endtask

  // One request: wait for accept, check the read, then the response.
  task automatic do_req(input op_e op, input int s, input int w, input bit keep,
                        input bit fl_rd, input int exp_wait);
    int         waited;
    logic [7:0] v_new;
    waited = 0;
    @(negedge clk);
    flush_req = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_set   = SET_W'(s);
    req_way   = WAY_W'(w);
    #1;
    while (!req_ready && waited < 400) begin
      @(negedge clk);
      flush_req = 1'b0;
      #1;
      waited++;
    end
    check("accept_wait", 64'(waited), 64'(exp_wait));
    check("rd_cmd", 64'({mem_en, rd_wr, mem_addr}), 64'({1'b1, 1'b0, 32'(s)}));
    case (op)
      OP_LOOKUP:  v_new = ref_vec[s];
      OP_SET_WAY: v_new = ref_vec[s] | (8'd1 << w);
      OP_CLR_WAY: v_new = ref_vec[s] & ~(8'd1 << w);
      default:    v_new = 8'h00;
    endcase
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    flush_req = fl_rd;
    #1;
    check("rsp", 64'({rsp_valid, rsp_vec}), 64'({1'b1, v_new}));
    if (op == OP_LOOKUP)
      check("lookup_noacc", 64'(mem_en), 64'(0));
    else
      check("wr_cmd", 64'({mem_en, rd_wr, mem_addr, mem_wdata}),
            64'({1'b1, 1'b1, 32'(s), v_new}));
    ref_vec[s] = v_new;
    last_rsp   = v_new;
    if (fl_rd) clear_ref();
  endtask

  // Flush pulse in IDLE with a competing request held high.
  task automatic flush_idle();
    @(negedge clk);
    flush_req = 1'b1;
    req_valid = 1'b1;
    req_op    = OP_LOOKUP;
    req_set   = SET_W'($urandom_range(0, 15));
    #1;
    check("flush_prio", 64'({req_ready, mem_en, flush_busy}), 64'(0));
    check_sweep(1'b0, 1'b0);
  endtask

  task automatic idle_gap(input int n);
    repeat (n) begin
      @(negedge clk);
      flush_req = 1'b0;
      #1;
      check("rsp_hold", 64'({rsp_valid, rsp_vec, mem_en}), 64'({1'b0, last_rsp, 1'b0}));
    end
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit  pend;
    int  kind;
    bit  keep;
    bit  fl;
    op_e op;

    clear_ref();
    repeat (2) @(posedge clk);
    #1 junk_fill = 1'b0;
    chk_reset("reset_vals");
    release_rst();
    check_sweep(1'b1, 1'b1);

    // Init result and basic set / clear sequence.
    do_req(OP_LOOKUP, 5, 0, 0, 0, 0);
    do_req(OP_SET_WAY, 3, 2, 0, 0, 0);
    check("set3_w2", 64'(last_rsp), 64'(8'h04));
    do_req(OP_SET_WAY, 3, 7, 0, 0, 0);
    check("set3_w7", 64'(last_rsp), 64'(8'h84));
    do_req(OP_LOOKUP, 3, 0, 0, 0, 0);
    do_req(OP_CLR_WAY, 3, 2, 0, 0, 0);
    check("clr3_w2", 64'(last_rsp), 64'(8'h80));
    do_req(OP_CLR_SET, 3, 0, 0, 0, 0);
    idle_gap(3);

    // Back-to-back to the same set with req_valid held high.
    do_req(OP_SET_WAY, 127, 0, 1, 0, 0);
    do_req(OP_SET_WAY, 127, 1, 1, 0, 0);
    do_req(OP_SET_WAY, 127, 2, 0, 0, 0);
    check("b2b_final", 64'(last_rsp), 64'(8'h07));
    idle_gap(2);

    // Flush beats a simultaneous request; the held request then runs.
    do_req(OP_SET_WAY, 10, 1, 0, 0, 0);
    flush_idle();
    do_req(OP_LOOKUP, 10, 0, 0, 0, 0);

    // Flush arriving during RDATA is deferred to the next IDLE.
    do_req(OP_SET_WAY, 20, 3, 0, 1, 0);
    @(negedge clk);
    flush_req = 1'b0;
    req_valid = 1'b1;
    req_op    = OP_LOOKUP;
    req_set   = SET_W'(20);
    #1;
    check("pend_block", 64'({req_ready, mem_en}), 64'(0));
    check_sweep(1'b0, 1'b0);
    do_req(OP_LOOKUP, 20, 0, 0, 0, 0);

    // Randomized traffic over a small set range to force reuse.
    pend = 1'b0;
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 15));
      if (kind == 0) begin
        flush_idle();
        pend = 1'b0;
      end else begin
        op   = op_e'(2'($urandom_range(0, 3)));
        keep = 1'($urandom_range(0, 1));
        fl   = ($urandom_range(0, 11) == 0);
        do_req(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), keep, fl,
               pend ? 129 : 0);
        pend = fl;
        if (!keep && !fl) idle_gap(int'($urandom_range(0, 2)));
      end
    end
    if (pend) begin
      do_req(OP_LOOKUP, 0, 0, 0, 0, 129);
    end

    // Reset in the middle of a flush sweep.
    do_req(OP_SET_WAY, 30, 5, 0, 0, 0);
    @(negedge clk);
    flush_req = 1'b1;
    req_valid = 1'b0;
    #1;
    for (int i = 0; i <= 60; i++) begin
      @(negedge clk);
      flush_req = 1'b0;
      #1;
    end
    check("sweep_at60", 64'({mem_en, mem_addr}), 64'({1'b1, 32'd60}));
    rst = 1'b0;
    #1;
    chk_reset("rst_sweep");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_reset("rst_sweep_hold");
    end
    release_rst();
    check_sweep(1'b1, 1'b1);
    do_req(OP_LOOKUP, 30, 0, 0, 0, 0);

    // Reset during RDATA of a modify op: no write-back may happen.
    do_req(OP_SET_WAY, 40, 6, 0, 0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_SET_WAY;
    req_set   = SET_W'(41);
    req_way   = WAY_W'(4);
    #1;
    check("rd_accept", 64'({req_ready, mem_en, rd_wr}), 64'(3'b110));
    @(negedge clk);
    #1;
    check("rd_rsp", 64'({rsp_valid, mem_en, rd_wr}), 64'(3'b111));
    rst = 1'b0;
    #1;
    chk_reset("rst_rdata");
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_reset("rst_rdata_hold");
    end
    release_rst();
    check_sweep(1'b1, 1'b0);
    do_req(OP_LOOKUP, 41, 0, 0, 0, 0);
    do_req(OP_LOOKUP, 40, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
